iter_shifter: RTL and testbench
===============================

// Module: iter_shifter
// PURPOSE
//  Multi-cycle, multi-mode barrel shifter: SLL, SRL, SRA, ROR on an N-bit operand.
//  Successor to the single-cycle arithmetic right shifter. Shifts at most STEP bits
//  per clock to trade latency for area, with valid/ready handshakes on both sides.
//  Sits beside the ALU as a variable-latency execution unit.
// PARAMETERS
//  N     32  operand/result width; power of 2, >= 8
//  STEP   4  max bits shifted per cycle; power of 2, 1 <= STEP <= N
//  (localparam SW = $clog2(N)+1: width of remaining-shift counter)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      request present on mode/a/shamt
//  in_ready   out  1      block can accept a request this cycle
//  mode       in   2      00 SLL, 01 SRL, 10 SRA, 11 ROR
//  a          in   N      operand
//  shamt      in   N      shift amount, full width, unsigned
//  out_valid  out  1      z holds a completed result
//  out_ready  in   1      consumer takes result this cycle
//  z          out  N      result (registered)
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, z=0, out_valid=0, busy=0, in_ready=1, counter=0.
//  - Accept = in_valid & in_ready. Latch a, mode and eff on accept; the inputs are
//    ignored otherwise.
//  - eff: SLL/SRL/SRA -> (shamt >= N) ? N : shamt (saturate: SLL/SRL give 0,
//    SRA gives all sign bits). ROR -> shamt[SW-2:0], i.e. shamt mod N.
//  - FSM IDLE/SHIFT/DONE:
//    - IDLE: on accept, go to DONE if eff==0 (z=a), else go to SHIFT (rem=eff).
//    - SHIFT: each cycle shift z by s=min(rem,STEP) per mode and set rem-=s.
//      SRA fills with the latched a[N-1]; ROR wraps. Go to DONE when rem<=STEP.
//    - DONE: out_valid=1. z and out_valid stay stable until out_ready.
//      On out_ready: a new accept that cycle goes straight to SHIFT/DONE;
//      otherwise go to IDLE.
//  - in_ready = (state==IDLE) | (state==DONE & out_ready); combinational from
//    state and out_ready. There is no combinational path from in_valid.
//  - Latency: with accept in cycle t and k=ceil(eff/STEP), out_valid is first high
//    in cycle t+1+k. Worst case is 1+N/STEP.
//  - out_valid never rises and falls without a handshake. A result is never dropped
//    or duplicated.
//  - rst mid-SHIFT or mid-DONE: the result is discarded and reset values apply the
//    next cycle.
//  - z is undefined-free: it is always either the reset value or a partial/complete
//    shift of a latched operand.
// TESTING (N=32, STEP=4)
//  1. SRA a=0x8000_0000 shamt=4, accept t -> out_valid at t+2, z=0xF800_0000.
//     shamt=0 -> out_valid at t+1, z=a.
//  2. SRL a=0x8000_0000 shamt=31 -> out_valid at t+9, z=0x0000_0001.
//     SLL a=0x1 shamt=31 -> z=0x8000_0000.
//  3. Saturation, shamt=0x40: SRA a=0x8000_0010 -> 0xFFFF_FFFF;
//     SRA a=0x7000_0000 -> 0x0; SLL/SRL -> 0x0. out_valid at t+9.
//  4. ROR a=0x0000_00F1 shamt=36 (eff 4) -> z=0x1000_000F at t+2.
//     ROR shamt=32 -> z=a at t+1.
//  5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> z, out_valid stable
//     and in_ready=0. Then out_ready=1 with in_valid=1 -> new request accepted in
//     the same cycle, back-to-back.
//  6. Assert rst during SHIFT -> next cycle out_valid=0, busy=0, in_ready=1, z=0.
//     A following request completes correctly.

Source files
------------

// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle SLL/SRL/SRA/ROR shifter, at most STEP bits per clock
module iter_shifter #(
    parameter int N    = 32,
    parameter int STEP = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   mode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] shamt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] z,
    output logic         busy
);

    localparam int SW = $clog2(N) + 1;
    localparam logic [SW-1:0] N_CNT    = SW'(N);
    localparam logic [SW-1:0] STEP_CNT = SW'(STEP);
    localparam logic [N-1:0]  N_WIDE   = N'(N);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t        state, state_nx;
    logic [N-1:0]  z_nx;
    logic [SW-1:0] rem, rem_nx;
    logic [1:0]    mode_q, mode_nx;
    logic          sign_q, sign_nx;
    logic [SW-1:0] eff;
    logic [SW-1:0] step_amt;
    logic          accept;

    // One partial shift of at most STEP bits; SRA fills from the operand's
    // original sign bit, not from the partially shifted value.
    function automatic logic [N-1:0] shift_once(
        input logic [1:0]    m,
        input logic [N-1:0]  v,
        input logic          sgn,
        input logic [SW-1:0] s
    );
        logic [2*N-1:0] wide;
        logic [N-1:0]   r;
        wide = '0;
        r    = v;
        case (m)
            MODE_SLL: r = v << s;
            MODE_SRL: r = v >> s;
            MODE_SRA: begin
                wide = {{N{sgn}}, v} >> s;
                r    = wide[N-1:0];
            end
            default: begin
                wide = {v, v} >> s;
                r    = wide[N-1:0];
            end
        endcase
        return r;
    endfunction

    // Linear shifts saturate at N; rotates only care about shamt mod N.
    always_comb begin
        eff = '0;
        if (mode == MODE_ROR)
            eff = {1'b0, shamt[SW-2:0]};
        else if (shamt >= N_WIDE)
            eff = N_CNT;
        else
            eff = shamt[SW-1:0];
    end

    assign step_amt  = (rem < STEP_CNT) ? rem : STEP_CNT;
    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        z_nx     = z;
        rem_nx   = rem;
        mode_nx  = mode_q;
        sign_nx  = sign_q;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    z_nx     = a;
                    mode_nx  = mode;
                    sign_nx  = a[N-1];
                    rem_nx   = eff;
                    state_nx = (eff == '0) ? DONE : SHIFT;
                end else if (state == DONE && out_ready) begin
                    state_nx = IDLE;
                end
            end
            SHIFT: begin
                z_nx   = shift_once(mode_q, z, sign_q, step_amt);
                rem_nx = rem - step_amt;
                if (rem <= STEP_CNT)
                    state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            z      <= '0;
            rem    <= '0;
            mode_q <= MODE_SLL;
            sign_q <= 1'b0;
        end else begin
            state  <= state_nx;
            z      <= z_nx;
            rem    <= rem_nx;
            mode_q <= mode_nx;
            sign_q <= sign_nx;
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
// tb/tb_iter_shifter.sv - randomized self-checking bench for iter_shifter
module tb_iter_shifter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  mode = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] z;
    logic        busy;

    int compared = 0;
    int mismatched = 0;

    iter_shifter #(.N(32), .STEP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .a(a), .shamt(shamt), .out_valid(out_valid),
        .out_ready(out_ready), .z(z), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [1:0] m, input logic [31:0] av,
                                               input logic [31:0] sh);
        int r;
        case (m)
            2'b00: return (sh >= 32) ? 32'h0 : (av << sh);
            2'b01: return (sh >= 32) ? 32'h0 : (av >> sh);
            2'b10: return (sh >= 32) ? (av[31] ? 32'hFFFF_FFFF : 32'h0) : 32'($signed(av) >>> sh);
            default: begin
                r = int'(sh % 32);
                if (r == 0) return av;
                return (av >> r) | (av << (32 - r));
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] m, input logic [31:0] sh);
        int e;
        if (m == 2'b11) e = int'(sh % 32);
        else e = (sh >= 32) ? 32 : int'(sh);
        return 1 + (e + 3) / 4;
    endfunction

    // Present a request, wait for accept, count cycles to out_valid, check z,
    // hold out_ready low for 'hold' cycles checking stability, then drain.
    task automatic do_op(input logic [1:0] m, input logic [31:0] av, input logic [31:0] sh,
                         input int hold, input string nm);
        int n;
        int lat;
        logic [31:0] exp_z;
        exp_z = ref_result(m, av, sh);
        @(negedge clk);
        mode = m; a = av; shamt = sh; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 in_valid = 1'b0; a = $urandom; shamt = $urandom; mode = 2'($urandom);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid && lat < 100);
        compared++;
        if (lat != ref_latency(m, sh)) begin
            mismatched++;
            $display("FAIL %s latency: got %0d want %0d", nm, lat, ref_latency(m, sh));
        end
        compared++;
        if (z !== exp_z) begin
            mismatched++;
            $display("FAIL %s z: got %h want %h", nm, z, exp_z);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            compared++;
            if (out_valid !== 1'b1 || z !== exp_z || in_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL %s hold: out_valid=%b z=%h in_ready=%b want 1 %h 0",
                         nm, out_valid, z, in_ready, exp_z);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || z !== 32'h0) begin
            mismatched++;
            $display("FAIL reset: out_valid=%b busy=%b in_ready=%b z=%h want 0 0 1 0",
                     out_valid, busy, in_ready, z);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        do_op(2'b10, 32'h8000_0000, 32'd4, 0, "sra4");
        do_op(2'b10, 32'h8000_0000, 32'd0, 0, "sra0");
        do_op(2'b01, 32'h8000_0000, 32'd31, 0, "srl31");
        do_op(2'b00, 32'h0000_0001, 32'd31, 0, "sll31");
        do_op(2'b10, 32'h8000_0010, 32'h40, 0, "sra_sat_neg");
        do_op(2'b10, 32'h7000_0000, 32'h40, 0, "sra_sat_pos");
        do_op(2'b00, 32'hFFFF_FFFF, 32'h40, 0, "sll_sat");
        do_op(2'b01, 32'hFFFF_FFFF, 32'h40, 0, "srl_sat");
        do_op(2'b11, 32'h0000_00F1, 32'd36, 0, "ror36");
        do_op(2'b11, 32'h0000_00F1, 32'd32, 0, "ror32");
        do_op(2'b00, 32'h1234_5678, 32'd32, 0, "sll32");
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] exp1, exp2;
        exp1 = ref_result(2'b11, 32'hDEAD_BEEF, 32'd4);
        exp2 = ref_result(2'b01, 32'hCAFE_F00D, 32'd9);
        @(negedge clk);
        mode = 2'b11; a = 32'hDEAD_BEEF; shamt = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 100);
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (out_valid !== 1'b1 || z !== exp1 || in_ready !== 1'b0 || busy !== 1'b1) begin
                mismatched++;
                $display("FAIL b2b hold%0d: out_valid=%b z=%h in_ready=%b busy=%b want 1 %h 0 1",
                         i, out_valid, z, in_ready, busy, exp1);
            end
            @(negedge clk);
        end
        mode = 2'b01; a = 32'hCAFE_F00D; shamt = 32'd9; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b in_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 100);
        compared++;
        if (n != 4 || z !== exp2) begin
            mismatched++;
            $display("FAIL b2b second: lat=%0d z=%h want 4 %h", n, z, exp2);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b drain: out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid_shift();
        @(negedge clk);
        mode = 2'b01; a = 32'h8000_0000; shamt = 32'd31; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL midshift busy: busy=%b out_valid=%b want 1 0", busy, out_valid);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || z !== 32'h0) begin
            mismatched++;
            $display("FAIL midshift reset: out_valid=%b busy=%b in_ready=%b z=%h want 0 0 1 0",
                     out_valid, busy, in_ready, z);
        end
        do_op(2'b10, 32'h9000_0001, 32'd13, 1, "after_reset");
    endtask

    task automatic test_random();
        logic [1:0]  m;
        logic [31:0] sh;
        for (int i = 0; i < 40; i++) begin
            m  = 2'($urandom);
            sh = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 40));
            do_op(m, 32'($urandom), sh, int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
